// File: rtl/match_game_fsm_if.sv
// Signal bundle between the memory-game controller and the menu, render, timer and card-RAM blocks.
// The controller connects through the slave modport. The surrounding system connects through the master modport.
interface match_game_fsm_if #(
  parameter int ADDR_W  = 5,
  parameter int COLOR_W = 12,
  parameter int CNT_W   = 6
);
  logic [CNT_W-1:0]   num_of_cards;
  logic               start_pressed;
  logic               level_pressed;
  logic               back_pressed;
  logic               compute_done;
  logic               card_pressed;
  logic [ADDR_W-1:0]  card_clicked_address;
  logic [COLOR_W-1:0] card_clicked_color;
  logic               time_passed;

  logic               start_butt_en;
  logic               options_screen_en;
  logic               start_game_en;
  logic               update_cards_en;
  logic               wait_for_click_en;
  logic               write_card_en;
  logic [1:0]         write_card_state;
  logic [ADDR_W-1:0]  write_card_address;
  logic               end_screen_en;
  logic               win;
  logic [7:0]         turns_ctr;
  logic [7:0]         misses_ctr;

  modport master (
    output num_of_cards, start_pressed, level_pressed, back_pressed, compute_done,
           card_pressed, card_clicked_address, card_clicked_color, time_passed,
    input  start_butt_en, options_screen_en, start_game_en, update_cards_en,
           wait_for_click_en, write_card_en, write_card_state, write_card_address,
           end_screen_en, win, turns_ctr, misses_ctr
  );

  modport slave (
    input  num_of_cards, start_pressed, level_pressed, back_pressed, compute_done,
           card_pressed, card_clicked_address, card_clicked_color, time_passed,
    output start_butt_en, options_screen_en, start_game_en, update_cards_en,
           wait_for_click_en, write_card_en, write_card_state, write_card_address,
           end_screen_en, win, turns_ctr, misses_ctr
  );
endinterface

// File: rtl/match_game_fsm.sv
// Memory-game controller for groups of MATCH_N cards.
// The game runs menu, level select, deal, reveal/resolve turns, then a time-out or miss-out sweep and the end screen.
module match_game_fsm #(
  parameter int ADDR_W      = 5,
  parameter int COLOR_W     = 12,
  parameter int CNT_W       = 6,
  parameter int MATCH_N     = 2,
  parameter int SHOW_CYCLES = 13_000_000,
  parameter int HOLD_CYCLES = 26_000_000,
  parameter int MAX_MISSES  = 0
) (
  input logic             clk,
  input logic             rst_n,
  match_game_fsm_if.slave bus
);
  localparam int MAX_DLY = (SHOW_CYCLES > HOLD_CYCLES) ? SHOW_CYCLES : HOLD_CYCLES;
  localparam int DLY_W   = $clog2(MAX_DLY + 1);
  localparam int IDX_W   = $clog2(MATCH_N + 1);
  localparam int SLOTS   = 1 << IDX_W;

  localparam logic [DLY_W-1:0] SHOW_LAST  = DLY_W'(SHOW_CYCLES - 1);
  localparam logic [DLY_W-1:0] HOLD_LAST  = DLY_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_FULL   = IDX_W'(MATCH_N);
  localparam logic [CNT_W-1:0] GROUP      = CNT_W'(MATCH_N);
  localparam logic [7:0]       MISS_LIMIT = 8'(MAX_MISSES);

  localparam logic [1:0] CARD_COVERED = 2'b01;
  localparam logic [1:0] CARD_REMOVED = 2'b10;
  localparam logic [1:0] CARD_FACEUP  = 2'b11;

  typedef enum logic [3:0] {
    S_MAIN_MENU, S_DEBOUNCE, S_CHOOSE_LEVEL, S_COMPUTE, S_REFRESH, S_SETTLE, S_WAIT_CLICK,
    S_REVEAL, S_CHECK, S_HOLD, S_RESOLVE, S_SWEEP, S_FINAL, S_END_SCREEN
  } state_e;

  state_e             state_q;
  logic [DLY_W-1:0]   dly_q;
  logic [IDX_W-1:0]   idx_q, res_q;
  logic [ADDR_W-1:0]  slot_addr_q  [SLOTS];
  logic [COLOR_W-1:0] slot_color_q [SLOTS];
  logic [ADDR_W-1:0]  pend_addr_q;
  logic [COLOR_W-1:0] pend_color_q;
  logic               mismatch_q;
  logic [CNT_W-1:0]   cards_left_q, num_cards_q, sweep_q;
  logic               start_butt_en_q, options_en_q, start_game_en_q, update_en_q;
  logic               click_en_q, end_en_q, wr_en_q, win_q;
  logic [1:0]         wr_state_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [7:0]         turns_q, misses_q;

  logic [7:0]         turns_d, misses_d;
  logic [CNT_W-1:0]   cards_left_d;
  logic               dup_click;

  assign turns_d      = (turns_q == 8'hFF) ? turns_q : turns_q + 8'd1;
  assign misses_d     = (misses_q == 8'hFF) ? misses_q : misses_q + 8'd1;
  assign cards_left_d = cards_left_q - GROUP;

  // A click on a card already face-up in the current group is dropped.
  always_comb begin
    // NOTE: default first so no path leaves dup_click unassigned (would infer a latch).
    dup_click = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (IDX_W'(i) < idx_q && slot_addr_q[i] == bus.card_clicked_address) dup_click = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_MAIN_MENU;
      dly_q           <= '0;
      idx_q           <= '0;
      res_q           <= '0;
      pend_addr_q     <= '0;
      pend_color_q    <= '0;
      mismatch_q      <= 1'b0;
      cards_left_q    <= '0;
      num_cards_q     <= '0;
      sweep_q         <= '0;
      start_butt_en_q <= 1'b0;
      options_en_q    <= 1'b0;
      start_game_en_q <= 1'b0;
      update_en_q     <= 1'b0;
      click_en_q      <= 1'b0;
      end_en_q        <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_state_q      <= '0;
      wr_addr_q       <= '0;
      win_q           <= 1'b0;
      turns_q         <= '0;
      misses_q        <= '0;
      // NOTE: the slot file is small and must start empty, so it is reset like any other register.
      for (int i = 0; i < SLOTS; i++) begin
        slot_addr_q[i]  <= '0;
        slot_color_q[i] <= '0;
      end
    end else begin
      start_butt_en_q <= (state_q == S_MAIN_MENU);
      options_en_q    <= (state_q == S_CHOOSE_LEVEL);
      start_game_en_q <= (state_q == S_COMPUTE);
      update_en_q     <= (state_q == S_REFRESH) || (state_q == S_FINAL) ||
                         (state_q == S_HOLD && dly_q == '0);
      click_en_q      <= (state_q == S_WAIT_CLICK);
      end_en_q        <= (state_q == S_END_SCREEN);
      wr_en_q         <= 1'b0;
      dly_q           <= '0;
      sweep_q         <= '0;

      case (state_q)
        S_MAIN_MENU:    if (bus.start_pressed) state_q <= S_DEBOUNCE;
        S_DEBOUNCE: begin
          if (dly_q == SHOW_LAST) state_q <= S_CHOOSE_LEVEL;
          else                    dly_q   <= dly_q + DLY_W'(1);
        end
        S_CHOOSE_LEVEL: begin
          if (bus.level_pressed)     state_q <= S_COMPUTE;
          else if (bus.back_pressed) state_q <= S_MAIN_MENU;
        end
        S_COMPUTE: begin
          cards_left_q <= bus.num_of_cards;
          num_cards_q  <= bus.num_of_cards;
          turns_q      <= '0;
          misses_q     <= '0;
          win_q        <= 1'b0;
          idx_q        <= '0;
          if (bus.compute_done) state_q <= S_REFRESH;
        end
        S_REFRESH: begin
          if (num_cards_q == '0) begin
            state_q <= S_FINAL;
            win_q   <= 1'b1;
          end else begin
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (dly_q == SHOW_LAST) state_q <= S_WAIT_CLICK;
          else                    dly_q   <= dly_q + DLY_W'(1);
        end
        S_WAIT_CLICK: begin
          if (bus.time_passed) begin
            state_q <= S_SWEEP;
          end else if (bus.card_pressed && !dup_click) begin
            pend_addr_q  <= bus.card_clicked_address;
            pend_color_q <= bus.card_clicked_color;
            state_q      <= S_REVEAL;
          end
        end
        S_REVEAL: begin
          slot_addr_q[idx_q]  <= pend_addr_q;
          slot_color_q[idx_q] <= pend_color_q;
          idx_q               <= idx_q + IDX_W'(1);
          wr_en_q             <= 1'b1;
          wr_state_q          <= CARD_FACEUP;
          wr_addr_q           <= pend_addr_q;
          state_q             <= S_CHECK;
        end
        S_CHECK: begin
          res_q <= '0;
          if (pend_color_q != slot_color_q[0]) begin
            mismatch_q <= 1'b1;
            state_q    <= S_HOLD;
          end else if (idx_q == IDX_FULL) begin
            mismatch_q <= 1'b0;
            state_q    <= S_HOLD;
          end else begin
            state_q    <= S_REFRESH;
          end
        end
        S_HOLD: begin
          if (dly_q == HOLD_LAST) state_q <= S_RESOLVE;
          else                    dly_q   <= dly_q + DLY_W'(1);
        end
        S_RESOLVE: begin
          wr_en_q    <= 1'b1;
          wr_addr_q  <= slot_addr_q[res_q];
          wr_state_q <= mismatch_q ? CARD_COVERED : CARD_REMOVED;
          res_q      <= res_q + IDX_W'(1);
          if (res_q == idx_q - IDX_W'(1)) begin
            idx_q   <= '0;
            turns_q <= turns_d;
            if (mismatch_q) begin
              misses_q <= misses_d;
              state_q  <= (MAX_MISSES != 0 && misses_d == MISS_LIMIT) ? S_SWEEP : S_REFRESH;
            end else begin
              cards_left_q <= cards_left_d;
              if (cards_left_d == '0) begin
                state_q <= S_FINAL;
                win_q   <= 1'b1;
              end else begin
                state_q <= S_REFRESH;
              end
            end
          end
        end
        S_SWEEP: begin
          if (sweep_q == num_cards_q) begin
            state_q <= S_FINAL;
            win_q   <= 1'b0;
          end else begin
            wr_en_q    <= 1'b1;
            wr_state_q <= CARD_REMOVED;
            wr_addr_q  <= ADDR_W'(sweep_q);
            sweep_q    <= sweep_q + CNT_W'(1);
          end
        end
        S_FINAL:      state_q <= S_END_SCREEN;
        S_END_SCREEN: if (bus.back_pressed) state_q <= S_MAIN_MENU;
        default:      state_q <= S_MAIN_MENU;
      endcase
    end
  end

  assign bus.start_butt_en      = start_butt_en_q;
  assign bus.options_screen_en  = options_en_q;
  assign bus.start_game_en      = start_game_en_q;
  assign bus.update_cards_en    = update_en_q;
  assign bus.wait_for_click_en  = click_en_q;
  assign bus.write_card_en      = wr_en_q;
  assign bus.write_card_state   = wr_state_q;
  assign bus.write_card_address = wr_addr_q;
  assign bus.end_screen_en      = end_en_q;
  assign bus.win                = win_q;
  assign bus.turns_ctr          = turns_q;
  assign bus.misses_ctr         = misses_q;
endmodule

// File: tb/tb_match_game_fsm.sv
// Directed bench for match_game_fsm with two instances sharing the stimulus:
// pairs with unlimited misses (dut2), and triples with a two-miss limit (dut3).
module tb_match_game_fsm;
  localparam int ADDR_W  = 5;
  localparam int COLOR_W = 12;
  localparam int CNT_W   = 6;
  localparam logic [COLOR_W-1:0] RED   = 12'hF00;
  localparam logic [COLOR_W-1:0] GREEN = 12'h0F0;
  localparam logic [COLOR_W-1:0] BLUE  = 12'h00F;
  localparam logic [1:0] COV = 2'b01, REM = 2'b10, UP = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2_n, rst3_n;
  int   dsel;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [6:0] wq[$];
  logic [6:0] eq[$];

  match_game_fsm_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .CNT_W(CNT_W)) if2 ();
  match_game_fsm_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .CNT_W(CNT_W)) if3 ();

  assign if3.num_of_cards         = if2.num_of_cards;
  assign if3.start_pressed        = if2.start_pressed;
  assign if3.level_pressed        = if2.level_pressed;
  assign if3.back_pressed         = if2.back_pressed;
  assign if3.compute_done         = if2.compute_done;
  assign if3.card_pressed         = if2.card_pressed;
  assign if3.card_clicked_address = if2.card_clicked_address;
  assign if3.card_clicked_color   = if2.card_clicked_color;
  assign if3.time_passed          = if2.time_passed;

  match_game_fsm #(
    .ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .CNT_W(CNT_W), .MATCH_N(2),
    .SHOW_CYCLES(2), .HOLD_CYCLES(2), .MAX_MISSES(0)
  ) dut2 (.clk(clk), .rst_n(rst2_n), .bus(if2));

  match_game_fsm #(
    .ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .CNT_W(CNT_W), .MATCH_N(3),
    .SHOW_CYCLES(2), .HOLD_CYCLES(2), .MAX_MISSES(2)
  ) dut3 (.clk(clk), .rst_n(rst3_n), .bus(if3));

  // Card-RAM write log; only one instance is out of reset at a time.
  always @(negedge clk) begin
    if (if2.write_card_en) wq.push_back({if2.write_card_state, if2.write_card_address});
    if (if3.write_card_en) wq.push_back({if3.write_card_state, if3.write_card_address});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic sig(input int code);
    case (code)
      0:       return (dsel == 2) ? if2.start_butt_en     : if3.start_butt_en;
      1:       return (dsel == 2) ? if2.options_screen_en : if3.options_screen_en;
      2:       return (dsel == 2) ? if2.start_game_en     : if3.start_game_en;
      3:       return (dsel == 2) ? if2.wait_for_click_en : if3.wait_for_click_en;
      4:       return (dsel == 2) ? if2.end_screen_en     : if3.end_screen_en;
      default: return (dsel == 2) ? if2.update_cards_en   : if3.update_cards_en;
    endcase
  endfunction

  function automatic logic [31:0] pack2();
    return {1'b0, if2.start_butt_en, if2.options_screen_en, if2.start_game_en, if2.update_cards_en,
            if2.wait_for_click_en, if2.write_card_en, if2.end_screen_en, if2.win,
            if2.turns_ctr, if2.misses_ctr, if2.write_card_state, if2.write_card_address};
  endfunction

  task automatic wait_sig(input int code, input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sig(code)) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // One-cycle button strobe, then one more cycle so the old enable has dropped.
  task automatic press(input int code);
    case (code)
      0:       if2.start_pressed = 1'b1;
      1:       if2.level_pressed = 1'b1;
      2:       if2.back_pressed  = 1'b1;
      default: if2.compute_done  = 1'b1;
    endcase
    @(negedge clk);
    if2.start_pressed = 1'b0;
    if2.level_pressed = 1'b0;
    if2.back_pressed  = 1'b0;
    if2.compute_done  = 1'b0;
    @(negedge clk);
  endtask

  task automatic click(input int addr, input logic [COLOR_W-1:0] color);
    if2.card_clicked_address = ADDR_W'(addr);
    if2.card_clicked_color   = color;
    if2.card_pressed         = 1'b1;
    @(negedge clk);
    if2.card_pressed = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_game(input int n);
    if2.num_of_cards = CNT_W'(n);
    wait_sig(0, "menu_screen");
    press(0);
    wait_sig(1, "level_screen");
    press(1);
    wait_sig(2, "compute_req");
    press(3);
    wait_sig(3, "click_ready");
  endtask

  task automatic exp_wr(input logic [1:0] st, input int addr);
    eq.push_back({st, ADDR_W'(addr)});
  endtask

  task automatic flush_writes(input string tag);
    check({tag, "_count"}, 32'(wq.size()), 32'(eq.size()));
    for (int i = 0; i < eq.size(); i++) begin
      if (i < wq.size()) check($sformatf("%s_wr%0d", tag, i), 32'(wq[i]), 32'(eq[i]));
    end
    wq.delete();
    eq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst2_n = 1'b0;
    rst3_n = 1'b0;
    dsel   = 2;
    if2.num_of_cards         = '0;
    if2.start_pressed        = 1'b0;
    if2.level_pressed        = 1'b0;
    if2.back_pressed         = 1'b0;
    if2.compute_done         = 1'b0;
    if2.card_pressed         = 1'b0;
    if2.card_clicked_address = '0;
    if2.card_clicked_color   = '0;
    if2.time_passed          = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", pack2(), 32'd0);
    rst2_n = 1'b1;
    @(negedge clk);
    check("menu_after_reset", 32'(if2.start_butt_en), 32'd1);

    // Pairs: match, duplicate click, mismatch, final match to a win.
    start_game(4);
    click(1, RED);
    wait_sig(3, "p1_first");
    click(2, RED);
    wait_sig(3, "p1_resolved");
    exp_wr(UP, 1); exp_wr(UP, 2); exp_wr(REM, 1); exp_wr(REM, 2);
    flush_writes("pair_match");
    check("pair_turns", 32'(if2.turns_ctr), 32'd1);
    check("pair_misses", 32'(if2.misses_ctr), 32'd0);

    click(0, GREEN);
    wait_sig(3, "p2_first");
    click(0, GREEN);
    repeat (4) @(negedge clk);
    check("dup_still_waiting", 32'(if2.wait_for_click_en), 32'd1);
    exp_wr(UP, 0);
    flush_writes("dup_click");
    click(3, BLUE);
    wait_sig(3, "p2_resolved");
    exp_wr(UP, 3); exp_wr(COV, 0); exp_wr(COV, 3);
    flush_writes("pair_miss");
    check("miss_turns", 32'(if2.turns_ctr), 32'd2);
    check("miss_misses", 32'(if2.misses_ctr), 32'd1);

    click(0, GREEN);
    wait_sig(3, "p3_first");
    click(3, GREEN);
    wait_sig(4, "win_end_screen");
    exp_wr(UP, 0); exp_wr(UP, 3); exp_wr(REM, 0); exp_wr(REM, 3);
    flush_writes("last_pair");
    check("win_flag", 32'(if2.win), 32'd1);
    check("win_turns", 32'(if2.turns_ctr), 32'd3);
    check("win_misses", 32'(if2.misses_ctr), 32'd1);
    press(2);

    // Time-out beats a simultaneous click.
    start_game(4);
    check("new_game_turns", 32'(if2.turns_ctr), 32'd0);
    check("new_game_misses", 32'(if2.misses_ctr), 32'd0);
    check("new_game_win", 32'(if2.win), 32'd0);
    if2.time_passed          = 1'b1;
    if2.card_pressed         = 1'b1;
    if2.card_clicked_address = 5'd2;
    if2.card_clicked_color   = RED;
    @(negedge clk);
    if2.time_passed  = 1'b0;
    if2.card_pressed = 1'b0;
    wait_sig(4, "timeout_end_screen");
    exp_wr(REM, 0); exp_wr(REM, 1); exp_wr(REM, 2); exp_wr(REM, 3);
    flush_writes("timeout_sweep");
    check("timeout_win", 32'(if2.win), 32'd0);
    press(2);

    // Reset while the mismatched pair is on display.
    start_game(4);
    click(1, RED);
    wait_sig(3, "r_first");
    click(2, BLUE);
    wait_sig(5, "hold_entered");
    rst2_n = 1'b0;
    @(negedge clk);
    check("reset_in_hold", pack2(), 32'd0);
    rst2_n = 1'b1;
    @(negedge clk);
    check("menu_after_release", 32'(if2.start_butt_en), 32'd1);
    exp_wr(UP, 1); exp_wr(UP, 2);
    flush_writes("hold_reset");

    // Triples with a two-miss limit.
    rst2_n = 1'b0;
    dsel   = 3;
    rst3_n = 1'b1;
    start_game(6);
    click(0, RED);
    wait_sig(3, "t1_a");
    click(1, RED);
    wait_sig(3, "t1_b");
    click(2, BLUE);
    wait_sig(3, "t1_resolved");
    exp_wr(UP, 0); exp_wr(UP, 1); exp_wr(UP, 2);
    exp_wr(COV, 0); exp_wr(COV, 1); exp_wr(COV, 2);
    flush_writes("triple_miss");
    check("triple_turns", 32'(if3.turns_ctr), 32'd1);
    check("triple_misses", 32'(if3.misses_ctr), 32'd1);

    click(2, BLUE);
    wait_sig(3, "t2_a");
    click(3, BLUE);
    wait_sig(3, "t2_b");
    click(4, RED);
    wait_sig(4, "missout_end_screen");
    exp_wr(UP, 2); exp_wr(UP, 3); exp_wr(UP, 4);
    exp_wr(COV, 2); exp_wr(COV, 3); exp_wr(COV, 4);
    for (int a = 0; a < 6; a++) exp_wr(REM, a);
    flush_writes("missout");
    check("missout_win", 32'(if3.win), 32'd0);
    check("missout_misses", 32'(if3.misses_ctr), 32'd2);
    check("missout_turns", 32'(if3.turns_ctr), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
